// File: rtl/fp_mul_param_unit.sv
// fp_mul_param_unit: iterative parametrised floating-point multiplier with rounding modes and exception flags
module fp_mul_param_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int STEP  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clk_en_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [EXP_W+MAN_W:0]   op_a_i,
  input  logic [EXP_W+MAN_W:0]   op_b_i,
  input  logic [2:0]             rm_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic [3:0]             flags_o
);
  localparam int M  = MAN_W + 1;
  localparam int P  = 2 * M;
  localparam int N  = (M + STEP - 1) / STEP;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic [EXP_W+MAN_W:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W+MAN_W-1:0] MAXF = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, PREPARE, MULTIPLY, NORMALIZE, ROUND, VALID} state_t;
  state_t state_q, state_d;

  logic [EXP_W+MAN_W:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]           rm_q, rm_d;
  logic                 sign_q, sign_d, special_q, special_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [P-1:0]         mc_q, mc_d, prod_q, prod_d;
  logic [M-1:0]         mb_q, mb_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           flags_q, flags_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, snan, is_nan, is_nv_inf, is_inf, special, sign_ab;
  logic signed [EW-1:0] exp_sum;
  logic [EXP_W+MAN_W:0] spec_res;
  logic [3:0] spec_flags;

  assign ea        = a_q[MAN_W +: EXP_W];
  assign eb        = b_q[MAN_W +: EXP_W];
  assign fa        = a_q[MAN_W-1:0];
  assign fb        = b_q[MAN_W-1:0];
  assign nan_a     = (&ea) & (|fa);
  assign nan_b     = (&eb) & (|fb);
  assign inf_a     = (&ea) & ~(|fa);
  assign inf_b     = (&eb) & ~(|fb);
  assign zero_a    = ~(|ea);
  assign zero_b    = ~(|eb);
  assign snan      = (nan_a & ~fa[MAN_W-1]) | (nan_b & ~fb[MAN_W-1]);
  assign is_nan    = nan_a | nan_b;
  assign is_nv_inf = (inf_a & zero_b) | (inf_b & zero_a);
  assign is_inf    = inf_a | inf_b;
  assign special   = is_nan | is_inf | zero_a | zero_b;
  assign sign_ab   = a_q[EXP_W+MAN_W] ^ b_q[EXP_W+MAN_W];
  assign exp_sum   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign spec_res  = (is_nan | is_nv_inf) ? QNAN :
                     is_inf ? {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign_ab, {(EXP_W+MAN_W){1'b0}}};
  assign spec_flags = {snan | (~is_nan & is_nv_inf), 3'b000};

  // After NORMALIZE prod_q holds the hidden bit at its MSB
  logic [M-1:0] man;
  logic g, r, s, nx, inc, to_inf, of, uf;
  logic [M:0] sum;
  logic signed [EW-1:0] exp_r;
  logic [MAN_W-1:0] frac_r;
  logic [EXP_W+MAN_W:0] rnd_res;
  logic [3:0] rnd_flags;

  assign man    = prod_q[P-1 -: M];
  assign g      = prod_q[P-1-M];
  assign r      = prod_q[P-2-M];
  assign s      = |prod_q[P-3-M:0];
  assign nx     = g | r | s;
  assign inc    = rm_q == 3'd1 ? 1'b0 : rm_q == 3'd2 ? nx & sign_q : rm_q == 3'd3 ? nx & ~sign_q :
                  rm_q == 3'd4 ? g : g & (r | s | man[0]);
  assign sum    = {1'b0, man} + {{M{1'b0}}, inc};
  assign exp_r  = exp_q + $signed({{(EW-1){1'b0}}, sum[M]});
  assign frac_r = sum[M] ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign of     = exp_r >= EMAX;
  assign uf     = exp_r <= EZERO;
  assign to_inf = rm_q == 3'd1 ? 1'b0 : rm_q == 3'd2 ? sign_q : rm_q == 3'd3 ? ~sign_q : 1'b1;
  assign rnd_res = of ? (to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign_q, MAXF}) :
                   uf ? {sign_q, {(EXP_W+MAN_W){1'b0}}} : {sign_q, exp_r[EXP_W-1:0], frac_r};
  assign rnd_flags = {1'b0, of, uf, nx | of | uf};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rm_d      = rm_q;
    sign_d    = sign_q;
    special_d = special_q;
    exp_d     = exp_q;
    mc_d      = mc_q;
    mb_d      = mb_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    flags_d   = flags_q;
    case (state_q)
      IDLE: if (valid_i && !flush_i) begin
        state_d = PREPARE;
        a_d     = op_a_i;
        b_d     = op_b_i;
        rm_d    = rm_i;
        flags_d = '0;
      end
      PREPARE: begin
        state_d   = special ? ROUND : MULTIPLY;
        sign_d    = sign_ab;
        special_d = special;
        exp_d     = exp_sum;
        res_d     = spec_res;
        flags_d   = spec_flags;
        mc_d      = P'({|ea, fa});
        mb_d      = {|eb, fb};
        prod_d    = '0;
        cnt_d     = '0;
      end
      MULTIPLY: begin
        prod_d  = prod_q + mc_q * P'(mb_q[STEP-1:0]);
        mc_d    = mc_q << STEP;
        mb_d    = mb_q >> STEP;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(N - 1) ? NORMALIZE : MULTIPLY;
      end
      NORMALIZE: begin
        prod_d  = prod_q[P-1] ? prod_q : prod_q << 1;
        exp_d   = exp_q + $signed({{(EW-1){1'b0}}, prod_q[P-1]});
        state_d = ROUND;
      end
      ROUND: begin
        res_d   = special_q ? res_q : rnd_res;
        flags_d = special_q ? flags_q : rnd_flags;
        state_d = VALID;
      end
      VALID:   state_d = ready_i ? IDLE : VALID;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rm_q      <= '0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      exp_q     <= '0;
      mc_q      <= '0;
      mb_q      <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else if (clk_en_i) begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rm_q      <= rm_d;
      sign_q    <= sign_d;
      special_q <= special_d;
      exp_q     <= exp_d;
      mc_q      <= mc_d;
      mb_q      <= mb_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
    end
  end

  assign ready_o  = state_q == IDLE;
  assign valid_o  = state_q == VALID;
  assign result_o = res_q;
  assign flags_o  = flags_q;
endmodule

// File: tb/tb_fp_mul_param_unit.sv
// tb_fp_mul_param_unit: directed scoreboard bench for the single-precision configuration
module tb_fp_mul_param_unit;
  logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, flush = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [2:0]  rm = '0;
  logic        ready_o, valid_o;
  logic [31:0] result_o;
  logic [3:0]  flags_o;

  fp_mul_param_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .flush_i(flush),
    .valid_i(valid_i), .ready_o(ready_o), .op_a_i(op_a), .op_b_i(op_b), .rm_i(rm),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] r; logic [3:0] f; int lat; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rmv,
                       input logic [31:0] er, input logic [3:0] ef, input int lat,
                       input int bp, input int stall_at);
    exp_t e, got;
    int cyc;
    e.r = er; e.f = ef; e.lat = lat;
    sb.push_back(e);
    chk("ready_before", ready_o, 1);
    op_a = a; op_b = b; rm = rmv; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      if (cyc == stall_at) clk_en = 1'b0;
      if (cyc == stall_at + 3) clk_en = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    clk_en = 1'b1;
    chk("valid_seen", valid_o, 1);
    got = sb.pop_front();
    chk("result", result_o, got.r);
    chk("flags", flags_o, got.f);
    chk("latency", cyc, got.lat);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result_o, got.r);
      chk("hold_flags", flags_o, got.f);
      chk("hold_ready", ready_o, 0);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("ready_after", ready_o, 1);
    chk("valid_after", valid_o, 0);
  endtask

  initial begin
    int v;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_flags", flags_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 4'h0, 15, 0, -1);
    do_op(32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40100000, 4'h0, 15, 0, -1);
    do_op(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 4'h8, 2, 0, -1);
    do_op(32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 4'h8, 2, 0, -1);
    do_op(32'h7FC00000, 32'h00000000, 3'd0, 32'h7FC00000, 4'h0, 2, 0, -1);
    do_op(32'hBF800000, 32'h7F800000, 3'd0, 32'hFF800000, 4'h0, 2, 0, -1);
    do_op(32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 4'h0, 2, 0, -1);
    do_op(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 4'h5, 15, 0, -1);
    do_op(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 4'h5, 15, 0, -1);
    do_op(32'h7F7FFFFF, 32'h40000000, 3'd5, 32'h7F800000, 4'h5, 15, 0, -1);
    do_op(32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 4'h5, 15, 0, -1);
    do_op(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 4'h5, 15, 0, -1);
    do_op(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 4'h1, 15, 0, -1);
    do_op(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 4'h1, 15, 0, -1);
    do_op(32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 4'h1, 15, 0, -1);
    do_op(32'h3F800001, 32'h3F800001, 3'd4, 32'h3F800002, 4'h1, 15, 0, -1);
    do_op(32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 4'h1, 15, 0, -1);
    do_op(32'h3FC00000, 32'h3F800001, 3'd0, 32'h3FC00002, 4'h1, 15, 0, -1);
    do_op(32'h3FC00000, 32'h3F800001, 3'd1, 32'h3FC00001, 4'h1, 15, 0, -1);
    do_op(32'h3FC00000, 32'h3F800003, 3'd0, 32'h3FC00004, 4'h1, 15, 0, -1);
    do_op(32'h3FC00000, 32'h3F800003, 3'd4, 32'h3FC00005, 4'h1, 15, 0, -1);
    do_op(32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 4'h3, 15, 0, -1);
    do_op(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 4'h0, 15, 5, -1);
    do_op(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 4'h0, 18, 0, 5);

    // flush raised during the fourth multiply cycle
    op_a = 32'h3FC00000; op_b = 32'h40000000; rm = 3'd0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", ready_o, 1);
    chk("flush_valid", valid_o, 0);
    v = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid_o) v++;
    end
    chk("flush_no_valid", v, 0);

    flush = 1'b1; valid_i = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid_i = 1'b0;
    chk("flush_idle_block", ready_o, 1);

    op_a = 32'h3FC00000; op_b = 32'h40000000; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_result", result_o, 0);
    v = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid_o) v++;
    end
    chk("midrst_no_valid", v, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
